// File: rtl/alm_pkg.sv
// alm_pkg: shared definitions for the ALM log-domain multiplier datapath.
//   LW_DEF / KMAX_DEF / TAG_W_DEF / SPLIT_DEF : default datapath geometry
//   set_one_mask(k) : mask with the low k bits set. The result is 32 bits
//                     wide and callers keep the low LW bits.
//   sat_k(k, kmax)  : clamps a requested set-one width to the supported maximum
//   s1_payload_t    : stage-1 payload layout for the default geometry
package alm_pkg;

    localparam int LW_DEF    = 19;
    localparam int KMAX_DEF  = 11;
    localparam int TAG_W_DEF = 4;
    localparam int SPLIT_DEF = LW_DEF / 2;
    localparam int KW_DEF    = $clog2(KMAX_DEF + 1);

    function automatic logic [31:0] set_one_mask(input int unsigned k);
        if (k >= 32)
            return '1;
        return (32'd1 << k) - 32'd1;
    endfunction

    function automatic int unsigned sat_k(input int unsigned k, input int unsigned kmax);
        return (k > kmax) ? kmax : k;
    endfunction

    // The partial low sum and its carry travel with the untouched high slices,
    // so stage 2 only has to finish the upper add and apply the mask.
    typedef struct packed {
        logic [SPLIT_DEF-1:0]        low;
        logic                        c1;
        logic [LW_DEF-SPLIT_DEF-1:0] a_hi;
        logic [LW_DEF-SPLIT_DEF-1:0] b_hi;
        logic [LW_DEF-SPLIT_DEF-1:0] cin_hi;
        logic [LW_DEF-1:0]           mask;
        logic [KW_DEF-1:0]           ke;
        logic [TAG_W_DEF-1:0]        tag;
    } s1_payload_t;

endpackage

// File: rtl/soa_pipe_slice.sv
// soa_pipe_slice: one valid/ready register stage of width DW.
//   clk, rst            : clock, synchronous active-high reset
//   up_valid / up_ready : upstream handshake
//   up_data             : upstream payload
//   dn_valid / dn_ready : downstream handshake
//   dn_data             : registered payload
// Handshake: a beat moves on a rising edge where valid and ready are both 1.
// The stage can load whenever it is empty or its current beat is leaving, so
// up_ready depends combinationally on dn_ready. There is no skid buffer.
module soa_pipe_slice #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          up_valid,
    output logic          up_ready,
    input  logic [DW-1:0] up_data,
    output logic          dn_valid,
    input  logic          dn_ready,
    output logic [DW-1:0] dn_data
);

    assign up_ready = !dn_valid || dn_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            dn_valid <= 1'b0;
            dn_data  <= '0;
        end else if (up_ready) begin
            dn_valid <= up_valid;
            // The data register is only written by a real beat. A bubble
            // therefore leaves the last result visible instead of overwriting it.
            if (up_valid)
                dn_data <= up_data;
        end
    end

endmodule

// File: rtl/soa_pipe.sv
// soa_pipe: 2-stage pipelined set-one adder for the ALM log-domain multiplier.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake
//   in_a, in_b           : LW-bit log operands
//   in_k                 : requested set-one width, saturated to KMAX
//   in_tag               : sideband tag, passed through unchanged
//   out_valid / out_ready: output handshake
//   out_sum              : LW+1-bit result. The MSB is the carry-out.
//   out_tag, out_k       : tag and applied (saturated) k of the beat in out_sum
// Stage 1 masks the operands and adds the low SPLIT bits. Stage 2 adds the
// high bits with the stage-1 carry and then ORs the mask over the result.
module soa_pipe
    import alm_pkg::*;
#(
    parameter int LW    = LW_DEF,
    parameter int KMAX  = KMAX_DEF,
    parameter int TAG_W = TAG_W_DEF,
    parameter int SPLIT = LW / 2,
    localparam int KW    = $clog2(KMAX + 1),
    localparam int KW_IN = $clog2(KMAX + 1) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LW-1:0]    in_a,
    input  logic [LW-1:0]    in_b,
    input  logic [KW_IN-1:0] in_k,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LW:0]      out_sum,
    output logic [TAG_W-1:0] out_tag,
    output logic [KW-1:0]    out_k
);

    localparam int HW = LW - SPLIT;

    typedef struct packed {
        logic [SPLIT-1:0] low;
        logic             c1;
        logic [HW-1:0]    a_hi;
        logic [HW-1:0]    b_hi;
        logic [HW-1:0]    cin_hi;
        logic [LW-1:0]    mask;
        logic [KW-1:0]    ke;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic [LW:0]      sum;
        logic [KW-1:0]    ke;
        logic [TAG_W-1:0] tag;
    } s2_t;

    // ---------------- stage 1 combinational ----------------
    logic [KW-1:0]  ke;
    logic [LW-1:0]  mask;
    logic [LW-1:0]  mask_top;
    logic           cin;
    logic [LW-1:0]  cinvec;
    logic [LW-1:0]  a_m;
    logic [LW-1:0]  b_m;
    logic [SPLIT:0] low_full;
    s1_t            s1_d;
    s1_t            s1_q;
    logic           s1_valid;
    logic           s2_ready;

    assign ke   = KW'(sat_k(32'(in_k), KMAX));
    assign mask = LW'(set_one_mask(32'(ke)));

    // The top set bit of the mask is bit ke-1. When ke is 0 the mask is empty,
    // so the carry term vanishes without a separate ke>0 test.
    assign mask_top = mask & ~(mask >> 1);
    assign cin      = |(in_a & in_b & mask_top);
    // cin << ke. Because KMAX < LW, bit ke always fits inside LW bits.
    assign cinvec   = cin ? (mask_top << 1) : '0;

    assign a_m = in_a & ~mask;
    assign b_m = in_b & ~mask;

    // The operands are multiples of 2^ke and the carry term is a single bit,
    // so this 3-input sum always fits in SPLIT+1 bits.
    assign low_full = {1'b0, a_m[SPLIT-1:0]} + {1'b0, b_m[SPLIT-1:0]}
                    + {1'b0, cinvec[SPLIT-1:0]};

    always_comb begin
        s1_d        = '0;
        s1_d.low    = low_full[SPLIT-1:0];
        s1_d.c1     = low_full[SPLIT];
        s1_d.a_hi   = a_m[LW-1:SPLIT];
        s1_d.b_hi   = b_m[LW-1:SPLIT];
        s1_d.cin_hi = cinvec[LW-1:SPLIT];
        s1_d.mask   = mask;
        s1_d.ke     = ke;
        s1_d.tag    = in_tag;
    end

    soa_pipe_slice #(.DW($bits(s1_t))) u_s1 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (in_valid),
        .up_ready (in_ready),
        .up_data  (s1_d),
        .dn_valid (s1_valid),
        .dn_ready (s2_ready),
        .dn_data  (s1_q)
    );

    // ---------------- stage 2 combinational ----------------
    logic [HW:0]    high_full;
    s2_t            s2_d;
    s2_t            s2_q;

    assign high_full = {1'b0, s1_q.a_hi} + {1'b0, s1_q.b_hi} + {1'b0, s1_q.cin_hi}
                     + {{HW{1'b0}}, s1_q.c1};

    always_comb begin
        s2_d     = '0;
        // When the mask covers low bits that produced a carry, the carry is
        // still propagated. The OR only overwrites the masked positions.
        s2_d.sum = {high_full, s1_q.low} | {1'b0, s1_q.mask};
        s2_d.ke  = s1_q.ke;
        s2_d.tag = s1_q.tag;
    end

    soa_pipe_slice #(.DW($bits(s2_t))) u_s2 (
        .clk      (clk),
        .rst      (rst),
        .up_valid (s1_valid),
        .up_ready (s2_ready),
        .up_data  (s2_d),
        .dn_valid (out_valid),
        .dn_ready (out_ready),
        .dn_data  (s2_q)
    );

    assign out_sum = s2_q.sum;
    assign out_k   = s2_q.ke;
    assign out_tag = s2_q.tag;

endmodule

// File: tb/tb_soa_pipe.sv
// tb_soa_pipe: directed and random checks of soa_pipe (LW=19, KMAX=11, SPLIT=9).
module tb_soa_pipe;

    localparam int LW    = 19;
    localparam int KMAX  = 11;
    localparam int TAG_W = 4;
    localparam int KW    = 4;
    localparam int KW_IN = 5;
    localparam int W     = LW + 1 + KW + TAG_W;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [LW-1:0]    in_a;
    logic [LW-1:0]    in_b;
    logic [KW_IN-1:0] in_k;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    wire              out_ready;
    logic [LW:0]      out_sum;
    logic [TAG_W-1:0] out_tag;
    logic [KW-1:0]    out_k;

    logic ready_ctl;
    logic rnd_en;
    logic rnd_bit;
    assign out_ready = rnd_en ? rnd_bit : ready_ctl;

    soa_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_k      (in_k),
        .in_tag    (in_tag),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_tag   (out_tag),
        .out_k     (out_k)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) rnd_bit <= 1'($urandom_range(0, 1));

    initial begin
        #900us;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- reference model ----------------
    function automatic int model_ke(input logic [KW_IN-1:0] k);
        return (int'(k) > KMAX) ? KMAX : int'(k);
    endfunction

    function automatic logic [LW:0] model_sum(input logic [LW-1:0] a, input logic [LW-1:0] b,
                                              input int ke);
        logic [LW:0] mask;
        logic [LW:0] cterm;
        logic        c;
        mask = (21'd1 << ke) - 21'd1;
        c = 1'b0;
        if (ke > 0)
            c = (((a >> (ke - 1)) & (b >> (ke - 1)) & 19'd1) != 19'd0);
        cterm = c ? ((LW+1)'(1) << ke) : '0;
        return (({1'b0, a} & ~mask) + ({1'b0, b} & ~mask) + cterm) | mask;
    endfunction

    // ---------------- scoreboard ----------------
    int vectors = 0;
    int miscompares = 0;
    int pops = 0;
    int out_cycle[16];
    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_w;
    logic [W-1:0] got_w;

    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid && out_ready) begin
                vectors++;
                pops++;
                got_w = {out_sum, out_k, out_tag};
                if (exp_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL sb_unexpected: got sum=%h k=%0d tag=%0d, required no output",
                             out_sum, out_k, out_tag);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (got_w !== exp_w) begin
                        miscompares++;
                        $display("FAIL sb_result: got sum=%h k=%0d tag=%0d, required sum=%h k=%0d tag=%0d",
                                 out_sum, out_k, out_tag, exp_w[W-1:KW+TAG_W],
                                 exp_w[KW+TAG_W-1:TAG_W], exp_w[TAG_W-1:0]);
                    end
                end
                out_cycle[out_tag] = cyc;
            end
            if (in_valid && in_ready)
                exp_q.push_back({model_sum(in_a, in_b, model_ke(in_k)),
                                 KW'(model_ke(in_k)), in_tag});
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [LW-1:0] a, input logic [LW-1:0] b,
                        input logic [KW_IN-1:0] k, input logic [TAG_W-1:0] tag);
        bit acc;
        acc = 1'b0;
        in_valid = 1'b1;
        in_a = a;
        in_b = b;
        in_k = k;
        in_tag = tag;
        for (int i = 0; i < 200 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: tag=%0d not accepted, required acceptance in 200 cycles", tag);
        end
    endtask

    task automatic idle();
        in_valid = 1'b0;
    endtask

    // Leaves the caller at the negedge where out_valid is seen.
    task automatic wait_out(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_timeout: out_valid=0, required 1 within 20 cycles", name);
        end
    endtask

    task automatic wait_drain(input string name);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 2000 && !done; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !out_valid) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            vectors++;
            miscompares++;
            $display("FAIL %s_drain: %0d beats outstanding, required 0", name, exp_q.size());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_out_valid: got %b, required 0", out_valid);
        end
        vectors++;
        if (out_sum !== 20'h0 || out_tag !== 4'h0 || out_k !== 4'h0) begin
            miscompares++;
            $display("FAIL reset_outputs: got sum=%h tag=%h k=%h, required all 0",
                     out_sum, out_tag, out_k);
        end
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_in_ready: got %b, required 1", in_ready);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_set_one_latency();
        send(19'h00018, 19'h00008, 5'd4, 4'd1);
        idle();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL latency_early: out_valid got %b one cycle after accept, required 0", out_valid);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL latency_two: out_valid got %b two cycles after accept, required 1", out_valid);
        end
        vectors++;
        if (out_sum !== 20'h0002F || out_k !== 4'd4) begin
            miscompares++;
            $display("FAIL set_one_k4: got sum=%h k=%0d, required sum=0002f k=4", out_sum, out_k);
        end
        @(posedge clk);
        #1;
        wait_drain("set_one");
    endtask

    task automatic test_exact_carry();
        send(19'h7FFFF, 19'h00001, 5'd0, 4'd2);
        idle();
        wait_out("exact");
        vectors++;
        if (out_sum !== 20'h80000 || out_k !== 4'd0) begin
            miscompares++;
            $display("FAIL exact_carry: got sum=%h k=%0d, required sum=80000 k=0", out_sum, out_k);
        end
        @(posedge clk);
        #1;
        wait_drain("exact");
    endtask

    task automatic test_saturation();
        send(19'h7FFFF, 19'h7FFFF, 5'd11, 4'd3);
        idle();
        wait_out("kmax");
        vectors++;
        if (out_sum !== 20'hFFFFF || out_k !== 4'd11) begin
            miscompares++;
            $display("FAIL kmax_sum: got sum=%h k=%0d, required sum=fffff k=11", out_sum, out_k);
        end
        @(posedge clk);
        #1;
        send(19'h7FFFF, 19'h7FFFF, 5'd15, 4'd4);
        idle();
        wait_out("sat");
        vectors++;
        if (out_sum !== 20'hFFFFF || out_k !== 4'd11) begin
            miscompares++;
            $display("FAIL sat_k15: got sum=%h k=%0d, required sum=fffff k=11", out_sum, out_k);
        end
        @(posedge clk);
        #1;
        wait_drain("sat");
    endtask

    task automatic test_back_to_back();
        logic [LW-1:0] a8;
        logic [LW-1:0] b8;
        logic [LW:0]   exp8;
        int p0;
        ready_ctl = 1'b1;
        for (int t = 0; t < 8; t++)
            send(19'($urandom()), 19'($urandom()), 5'($urandom_range(0, 20)), 4'(t));
        idle();
        wait_drain("b2b");
        for (int t = 1; t < 8; t++) begin
            vectors++;
            if (out_cycle[t] !== out_cycle[0] + t) begin
                miscompares++;
                $display("FAIL b2b_spacing: tag %0d at cycle %0d, required %0d",
                         t, out_cycle[t], out_cycle[0] + t);
            end
        end

        // Stall: fill both stages, then hold the output and wiggle in_valid.
        p0 = pops;
        ready_ctl = 1'b0;
        a8 = 19'h12345;
        b8 = 19'h0ABCD;
        exp8 = model_sum(a8, b8, 6);
        send(a8, b8, 5'd6, 4'd8);
        send(19'h3FFFF, 19'h00FFF, 5'd10, 4'd9);
        in_a = 19'h55555;
        in_b = 19'h2AAAA;
        in_k = 5'd9;
        in_tag = 4'd10;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_sum !== exp8 || out_tag !== 4'd8) begin
                miscompares++;
                $display("FAIL stall_hold: cycle %0d got in_ready=%b out_valid=%b sum=%h tag=%0d, required 0 1 %h 8",
                         i, in_ready, out_valid, out_sum, out_tag, exp8);
            end
            @(posedge clk);
            #1;
            in_valid = (i % 2 == 0) ? 1'b0 : 1'b1;
        end
        ready_ctl = 1'b1;
        send(19'h55555, 19'h2AAAA, 5'd9, 4'd10);
        idle();
        wait_drain("stall");
        vectors++;
        if (pops - p0 !== 3) begin
            miscompares++;
            $display("FAIL stall_count: got %0d results, required 3", pops - p0);
        end
    endtask

    task automatic test_reset_in_flight();
        ready_ctl = 1'b0;
        send(19'h11111, 19'h22222, 5'd3, 4'd11);
        send(19'h33333, 19'h44444, 5'd5, 4'd12);
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b0 || out_sum !== 20'h0 || in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL flight_reset: got out_valid=%b sum=%h in_ready=%b, required 0 00000 1",
                     out_valid, out_sum, in_ready);
        end
        @(posedge clk);
        #1;
        ready_ctl = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vectors++;
            if (out_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL flight_dropped: out_valid got %b after reset, required 0", out_valid);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_random();
        int p0;
        logic [LW-1:0] a;
        logic [LW-1:0] b;
        p0 = pops;
        ready_ctl = 1'b1;
        // Mask spans SPLIT, and the all-ones-low case at ke=KMAX.
        send(19'h003FF, 19'h00200, 5'd10, 4'd0);
        send(19'h007FF, 19'h3F7FF, 5'd11, 4'd1);
        send(19'h7FFFF, 19'h7FFFF, 5'd0, 4'd2);
        rnd_en = 1'b1;
        for (int n = 0; n < 10000; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle();
                @(posedge clk);
                #1;
            end
            a = 19'($urandom());
            b = 19'($urandom());
            if ($urandom_range(0, 15) == 0) a = '1;
            if ($urandom_range(0, 15) == 0) b = '1;
            send(a, b, 5'($urandom_range(0, 31)), 4'(n));
        end
        idle();
        rnd_en = 1'b0;
        wait_drain("random");
        vectors++;
        if (pops - p0 !== 10003) begin
            miscompares++;
            $display("FAIL random_count: got %0d results, required 10003", pops - p0);
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_a = '0;
        in_b = '0;
        in_k = '0;
        in_tag = '0;
        ready_ctl = 1'b1;
        rnd_en = 1'b0;
        for (int i = 0; i < 16; i++) out_cycle[i] = 0;
        test_reset();
        test_set_one_latency();
        test_exact_carry();
        test_saturation();
        test_back_to_back();
        test_reset_in_flight();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
